// File: rtl/game_supervisor.sv
// game_supervisor: key debounce, game FSM, block countdown and LED driver in one block.
// Define GAME_SUPERVISOR_PAUSE_EN to let a key press in RUN toggle a pause.
module game_supervisor #(
  parameter int TICK_CYCLES     = 1000,
  parameter int BLOCK_W         = 4,
  parameter int BLOCK_INIT      = 10,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int BLINK_CYCLES    = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_start,
  input  logic                collision_detected,
  output logic [1:0]          state,
  output logic [BLOCK_W-1:0]  block_remain,
  output logic                tick,
  output logic                game_clear,
  output logic                paused,
  output logic [NUM_LEDS-1:0] led_red,
  output logic [NUM_LEDS-1:0] led_green
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_OVER  = 2'b10;
  localparam logic [1:0] ST_CLEAR = 2'b11;

  localparam int TCW = $clog2(TICK_CYCLES);
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PCW = $clog2(2 * BLINK_CYCLES);

  localparam logic [TCW-1:0]     TICK_LAST  = TCW'(TICK_CYCLES - 1);
  localparam logic [DCW-1:0]     DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCW-1:0]     PHASE_LAST = PCW'(2 * BLINK_CYCLES - 1);
  localparam logic [PCW-1:0]     PHASE_ON   = PCW'(BLINK_CYCLES);
  localparam logic [BLOCK_W-1:0] BLOCK_LOAD = BLOCK_W'(BLOCK_INIT);

  logic           key_s1, key_s2, key_db, key_db_q;
  logic [DCW-1:0] deb_cnt;
  logic           coll_s1, coll_s2;
  logic           press;
  logic [TCW-1:0] tick_cnt;
  logic           run_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= 1'b0;
      key_s2   <= 1'b0;
      key_db   <= 1'b0;
      key_db_q <= 1'b0;
      deb_cnt  <= '0;
      coll_s1  <= 1'b0;
      coll_s2  <= 1'b0;
    end else begin
      key_s1   <= key_start;
      key_s2   <= key_s1;
      key_db_q <= key_db;
      coll_s1  <= collision_detected;
      coll_s2  <= coll_s1;
      if (key_s2 == key_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_db  <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DCW'(1);
      end
    end
  end

  assign press      = key_db & ~key_db_q;
  assign game_clear = (state == ST_CLEAR);

`ifdef GAME_SUPERVISOR_PAUSE_EN
  logic pause_q;
  // The pausing/resuming press edge itself does not advance the tick counter.
  assign run_hold = pause_q | press;
  assign paused   = pause_q;
`else
  assign run_hold = 1'b0;
  assign paused   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      block_remain <= BLOCK_LOAD;
      tick_cnt     <= '0;
      tick         <= 1'b0;
`ifdef GAME_SUPERVISOR_PAUSE_EN
      pause_q      <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state        <= ST_RUN;
            block_remain <= BLOCK_LOAD;
            tick_cnt     <= '0;
          end
        end
        ST_RUN: begin
          // Collision wins over a same-cycle tick or press and freezes the count.
          if (coll_s2) begin
            state <= ST_OVER;
`ifdef GAME_SUPERVISOR_PAUSE_EN
            pause_q <= 1'b0;
`endif
          end else begin
`ifdef GAME_SUPERVISOR_PAUSE_EN
            if (press) pause_q <= ~pause_q;
`endif
            if (!run_hold) begin
              if (tick_cnt == TICK_LAST) begin
                tick_cnt     <= '0;
                tick         <= 1'b1;
                block_remain <= block_remain - BLOCK_W'(1);
                if (block_remain == BLOCK_W'(1)) state <= ST_CLEAR;
              end else begin
                tick_cnt <= tick_cnt + TCW'(1);
              end
            end
          end
        end
        default: begin
          if (press) begin
            state        <= ST_IDLE;
            block_remain <= BLOCK_LOAD;
          end
        end
      endcase
    end
  end

  logic [1:0]     prev_state;
  logic           prev_paused;
  logic [PCW-1:0] phase, phase_eff;
  logic           blink_on, red_on, green_on;

  // Blink phase restarts whenever the displayed condition changes.
  always_comb begin
    phase_eff = ((state != prev_state) || (paused != prev_paused)) ? '0 : phase;
    blink_on  = (phase_eff < PHASE_ON);
    red_on    = 1'b0;
    green_on  = 1'b0;
    case (state)
      ST_RUN:   green_on = paused ? blink_on : 1'b1;
      ST_OVER:  red_on   = blink_on;
      ST_CLEAR: begin
        red_on   = 1'b1;
        green_on = 1'b1;
      end
      default: begin
        red_on   = 1'b0;
        green_on = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state  <= ST_IDLE;
      prev_paused <= 1'b0;
      phase       <= '0;
      led_red     <= '0;
      led_green   <= '0;
    end else begin
      prev_state  <= state;
      prev_paused <= paused;
      phase       <= (phase_eff == PHASE_LAST) ? '0 : phase_eff + PCW'(1);
      led_red     <= {NUM_LEDS{red_on}};
      led_green   <= {NUM_LEDS{green_on}};
    end
  end

endmodule
